// File: rtl/seven_seg_scan_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_if
//   Connects the datapath side to the seven-segment scan driver. The datapath
//   holds the master modport. The driver holds the slave modport.
//
//   Parameter
//     DIGITS  number of digits; sets the width of data, dp and an
//
//   Signals
//     load     master->slave  one-cycle strobe that captures data/dp
//     data     master->slave  4*DIGITS nibbles; digit 0 = data[3:0] (rightmost)
//     dp       master->slave  decimal point per digit; dp[i] belongs to digit i
//     blank    master->slave  level; 1 turns all anodes off
//     seg      slave->master  {dp,g,f,e,d,c,b,a} for the selected digit
//     an       slave->master  one-hot anode select
//     pending  slave->master  loaded data is waiting for the frame boundary
//     frame    slave->master  one-cycle pulse when the scan wraps to digit 0
// ---------------------------------------------------------------------------
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic                  blank;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  frame;

  modport master (
    output load, data, dp, blank,
    input  seg, an, pending, frame
  );

  modport slave (
    input  load, data, dp, blank,
    output seg, an, pending, frame
  );
endinterface

// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//   Time-multiplexed driver for a multi-digit common-anode seven-segment
//   display with decimal points. Each digit stays lit for SCAN_DIV clocks.
//   New data is taken in with a one-cycle load strobe. It is held in a pending
//   buffer and goes to the display only at a frame boundary, so a frame never
//   shows a mix of old and new digits.
//
//   Parameters
//     DIGITS      number of digits scanned (1..8)
//     SCAN_DIV    clocks each digit stays lit (>= 2)
//     ACTIVE_LOW  1 = seg/an driven active-low, 0 = active-high
//
//   Ports
//     clk   system clock; all logic uses the rising edge
//     rst   synchronous reset, active-high; overrides every other input
//     bus   seven_seg_scan_if.slave with load/data/dp/blank in and
//           seg/an/pending/frame out
//
//   Optional feature
//     SEVEN_SEG_HEX_EN  when defined, nibbles 10..15 decode as A,b,C,d,E,F.
//                       When undefined they show no segments. The decimal
//                       point is still shown.
// ---------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  seven_seg_scan_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                            : {DIGITS{1'b0}};

  // Active-high segment pattern {g,f,e,d,c,b,a} for a nibble.
  function automatic logic [6:0] decode_nibble(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
`ifdef SEVEN_SEG_HEX_EN
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
`endif
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Scan state
  logic [CNT_W-1:0]    cnt_reg,   cnt_next;
  logic [IDX_W-1:0]    idx_reg,   idx_next;
  logic                frame_reg, frame_next;

  // Data currently shown, plus the buffer that waits for the frame boundary
  logic [4*DIGITS-1:0] disp_data_reg, disp_data_next;
  logic [DIGITS-1:0]   disp_dp_reg,   disp_dp_next;
  logic [4*DIGITS-1:0] pend_data_reg, pend_data_next;
  logic [DIGITS-1:0]   pend_dp_reg,   pend_dp_next;
  logic                pending_reg,   pending_next;

  // Registered pin stage
  logic [7:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   an_reg,  an_next;

  // Control decodes
  logic                scan_wrap;
  logic                frame_end;

  assign scan_wrap = (cnt_reg == CNT_MAX);
  assign frame_end = scan_wrap && (idx_reg == IDX_MAX);

  // Active-high segment pattern for every digit, and the one-hot anode
  // vector. The pin stage selects from these by idx.
  logic [7:0]        digit_seg [DIGITS];
  logic [DIGITS-1:0] an_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_seg[gi] = {disp_dp_reg[gi],
                              decode_nibble(disp_data_reg[4*gi +: 4])};
      assign an_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Mux built by comparison, so a DIGITS value that is not a power of two
  // does not need an out-of-range array index.
  logic [7:0] seg_sel;
  always_comb begin
    seg_sel = 8'h00;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        seg_sel = digit_seg[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    frame_next     = frame_end;
    disp_data_next = disp_data_reg;
    disp_dp_next   = disp_dp_reg;
    pend_data_next = pend_data_reg;
    pend_dp_next   = pend_dp_reg;
    pending_next   = pending_reg;

    if (scan_wrap) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + IDX_W'(1);
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    if (frame_end) begin
      // A strobe in the frame-end cycle goes straight to the display. It
      // takes priority over any older pending buffer.
      if (bus.load) begin
        disp_data_next = bus.data;
        disp_dp_next   = bus.dp;
      end else if (pending_reg) begin
        disp_data_next = pend_data_reg;
        disp_dp_next   = pend_dp_reg;
      end
      pending_next = 1'b0;
    end else if (bus.load) begin
      // The latest strobe before the boundary wins.
      pend_data_next = bus.data;
      pend_dp_next   = bus.dp;
      pending_next   = 1'b1;
    end

    // blank gates only the anodes. seg and the scan keep running, so the
    // scan phase is kept when blank is released.
    seg_next = (ACTIVE_LOW != 0) ? ~seg_sel : seg_sel;
    if (bus.blank) begin
      an_next = AN_OFF;
    end else begin
      an_next = (ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      frame_reg     <= 1'b0;
      disp_data_reg <= '0;
      disp_dp_reg   <= '0;
      pend_data_reg <= '0;
      pend_dp_reg   <= '0;
      pending_reg   <= 1'b0;
      seg_reg       <= SEG_OFF;
      an_reg        <= AN_OFF;
    end else begin
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      frame_reg     <= frame_next;
      disp_data_reg <= disp_data_next;
      disp_dp_reg   <= disp_dp_next;
      pend_data_reg <= pend_data_next;
      pend_dp_reg   <= pend_dp_next;
      pending_reg   <= pending_next;
      seg_reg       <= seg_next;
      an_reg        <= an_next;
    end
  end

  assign bus.seg     = seg_reg;
  assign bus.an      = an_reg;
  assign bus.pending = pending_reg;
  assign bus.frame   = frame_reg;

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Time-multiplexed driver for a parametrised multi-digit common-anode seven-segment display with decimal points. It sits between the datapath (BCD/hex nibbles plus DP flags) and the board display pins. It generalises the single-digit combinational nibble decoder with three additions: digit scanning, tear-free load at frame boundaries, and selectable output polarity.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, CLK cycles each digit stays lit (>=2)
ACTIVE_LOW, 1, 1 = SEG/AN driven active-low, 0 = active-high

Ports:
CLK  in  1  system clock, all logic rising-edge
RST  in  1  synchronous reset, active-high
LOAD  in  1  one-cycle strobe, capture DATA/DP
DATA  in  4*DIGITS  nibble per digit, digit 0 = DATA[3:0], rightmost
DP  in  DIGITS  decimal point per digit, DP[i] belongs to digit i
BLANK  in  1  level; 1 = all anodes off
SEG  out  8  {dp,g,f,e,d,c,b,a} for the currently selected digit
AN  out  DIGITS  one-hot anode select
PENDING  out  1  loaded data waiting for the frame boundary
FRAME  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- One clock, CLK; RST is synchronous and active-high. RST overrides every other input.
- Reset values:
  - cnt=0, idx=0, display regs (disp_data, disp_dp) = 0, pend regs = 0.
  - PENDING=0, FRAME=0.
  - SEG and AN are "all off": all 1s if ACTIVE_LOW, else all 0s.
- Scan counter:
  - cnt counts 0..SCAN_DIV-1.
  - In the cycle where cnt==SCAN_DIV-1: cnt<=0 and idx<=idx+1.
  - idx wraps from DIGITS-1 to 0 with no gaps or skips.
- Frame end: the cycle where cnt==SCAN_DIV-1 and idx==DIGITS-1. At that edge FRAME<=1 for exactly one cycle, coincident with idx becoming 0.
- Load handshake:
  - LOAD=1 outside frame end: pend<=DATA/DP, PENDING<=1.
  - A second LOAD before the boundary overwrites pend; the last one wins.
  - At frame end with PENDING=1 and LOAD=0: disp<=pend, PENDING<=0.
  - At frame end with LOAD=1: disp<=DATA/DP directly and PENDING<=0. The current input wins over an older pend.
  - The display therefore never changes mid-frame (tear-free).
- Output stage is registered, giving 1-cycle latency from idx/disp to pins:
  - AN: bit idx active, all others inactive.
  - SEG: decode(disp nibble[idx]) with dp = disp_dp[idx].
- Decode, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10..15: see optional feature.
  - ACTIVE_LOW inverts all 8 SEG bits and all AN bits.
- BLANK=1: the next AN register value is all inactive. SEG still updates. The scan counter keeps running so phase is preserved; on BLANK release, output resumes on the next cycle at the current idx.
- RST asserted mid-frame or with PENDING=1: pend is discarded and the display returns to 0s. Pins show "all off" the cycle after the reset edge; digit 0 appears one cycle after RST deasserts.
- DIGITS=1: idx is constant 0 and every scan-period end is a frame end. FRAME pulses once per SCAN_DIV cycles.

Optional Feature:
- Macro SEVEN_SEG_HEX_EN.
- Defined: nibbles 10..15 decode as hex A=77, b=7C, C=39, d=5E, E=79, F=71.
- Undefined: nibbles 10..15 decode to segments off (00 before polarity). DP is still shown.
- The macro has no effect on timing or the other ports.

Test Plan:
- DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1; hold RST 3 cycles -> SEG=FF, AN=F during reset. After release, AN cycles E,D,B,7 in 4-cycle steps; FRAME pulses every 16 cycles.
- LOAD DATA=16'h1234, DP=4'b0010 mid-frame -> PENDING=1 until frame end, display unchanged. Next frame gives digit0 SEG=~8'h66=99, digit1 SEG=~(8'h4F|80)=30, digit2=~5B=A4, digit3=~06=F9.
- LOAD twice in one frame (16'h1111, then 16'h9999) -> only 9999 shown (SEG=90 on every digit). LOAD in the frame-end cycle with 16'h0000 -> display shows 0000 (SEG=C0) next frame, PENDING stays 0.
- BLANK=1 for 10 cycles -> AN=F throughout; on release, AN resumes at the same idx phase as an unblanked reference counter.
- DATA=16'hABCD -> with SEVEN_SEG_HEX_EN, digit0 SEG=~5E=A1 and digit3 SEG=~77=88; without the macro, all digits SEG=FF.
- RST pulse while PENDING=1 mid-frame -> PENDING=0, display all zeros, FRAME=0, scan restarts at digit 0 with cnt=0.
